// File: rtl/branch_decoder_unit.sv
// Branch decoder: selects the next-PC source from the branch kind and, for
// conditional branches, from an rs1/rs2 comparison. Also keeps a registered
// copy of the select and a saturating count of redirecting cycles.
//
// Ports:
//   clock            - rising-edge clock for all registered state
//   reset_n          - synchronous active-low reset
//   branch_type      - branch_t encoding (NoBranch/Mret/Sret/Jump/CondBranch)
//   cond_branch_type - cond_branch_t encoding (RISC-V funct3)
//   read_data_1      - rs1 operand
//   read_data_2      - rs2 operand
//   pc_src           - next-PC select (combinational)
//   taken            - pc_src != PcPlus4Src (combinational)
//   pc_src_q         - pc_src registered one cycle
//   redirect_count   - saturating count of cycles with taken=1

package branch_decoder_unit_pkg;

    typedef enum logic [2:0] {
        NoBranch   = 3'd0,
        Mret       = 3'd1,
        Sret       = 3'd2,
        Jump       = 3'd3,
        CondBranch = 3'd4
    } branch_t;

    typedef enum logic [2:0] {
        Beq  = 3'd0,
        Bne  = 3'd1,
        Blt  = 3'd4,
        Bge  = 3'd5,
        Bltu = 3'd6,
        Bgeu = 3'd7
    } cond_branch_t;

    typedef enum logic [1:0] {
        PcPlus4Src             = 2'b00,
        SepcSrc                = 2'b01,
        MepcSrc                = 2'b10,
        PcOrReadDataPlusImmSrc = 2'b11
    } pc_src_t;

endpackage

module branch_decoder_unit
    import branch_decoder_unit_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       branch_type,
    input  logic [2:0]       cond_branch_type,
    input  logic [Width-1:0] read_data_1,
    input  logic [Width-1:0] read_data_2,
    output logic [1:0]       pc_src,
    output logic             taken,
    output logic [1:0]       pc_src_q,
    output logic [31:0]      redirect_count
);

    localparam int unsigned CountWidth = 32;
    localparam logic [CountWidth-1:0] CountMax = '1;

    logic equal;
    logic less_signed;
    logic less_unsigned;
    logic cond_holds;

    // Operand comparisons; signed compare uses the MSB at full Width as sign.
    assign equal         = (read_data_1 == read_data_2);
    assign less_signed   = ($signed(read_data_1) < $signed(read_data_2));
    assign less_unsigned = (read_data_1 < read_data_2);

    // Condition evaluation; undefined funct3 encodings never hold.
    always_comb begin
        cond_holds = 1'b0;
        case (cond_branch_type)
            Beq:     cond_holds = equal;
            Bne:     cond_holds = !equal;
            Blt:     cond_holds = less_signed;
            Bge:     cond_holds = !less_signed;
            Bltu:    cond_holds = less_unsigned;
            Bgeu:    cond_holds = !less_unsigned;
            default: cond_holds = 1'b0;
        endcase
    end

    // Next-PC select; undefined branch kinds fall through to PC+4.
    always_comb begin
        pc_src = PcPlus4Src;
        case (branch_type)
            Sret:       pc_src = SepcSrc;
            Mret:       pc_src = MepcSrc;
            Jump:       pc_src = PcOrReadDataPlusImmSrc;
            CondBranch: pc_src = cond_holds ? PcOrReadDataPlusImmSrc : PcPlus4Src;
            default:    pc_src = PcPlus4Src;
        endcase
    end

    assign taken = (pc_src != PcPlus4Src);

    // Registered select and saturating redirect counter; reset wins over increment.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_src_q       <= PcPlus4Src;
            redirect_count <= '0;
        end else begin
            pc_src_q <= pc_src;
            if (taken && (redirect_count != CountMax)) begin
                redirect_count <= redirect_count + CountWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_decoder_unit.sv
// Testbench for branch_decoder_unit: directed and randomized stimulus checked
// against a behavioural reference model of the next-PC selection rules.

module tb_branch_decoder_unit;

    logic        clock;
    logic        reset_n;
    logic [2:0]  branch_type;
    logic [2:0]  cond_branch_type;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [1:0]  pc_src;
    logic        taken;
    logic [1:0]  pc_src_q;
    logic [31:0] redirect_count;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  m_q;
    logic [31:0] m_cnt;

    branch_decoder_unit #(.Width(32)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .branch_type      (branch_type),
        .cond_branch_type (cond_branch_type),
        .read_data_1      (read_data_1),
        .read_data_2      (read_data_2),
        .pc_src           (pc_src),
        .taken            (taken),
        .pc_src_q         (pc_src_q),
        .redirect_count   (redirect_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: does the funct3 condition hold for these operands?
    function automatic bit model_cond(input logic [2:0] cbt, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (cbt)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: next-PC select for a given branch kind.
    function automatic logic [1:0] model_pc(input logic [2:0] bt, input logic [2:0] cbt,
                                            input logic [31:0] a, input logic [31:0] b);
        case (bt)
            3'd0:    return 2'b00;
            3'd1:    return 2'b10;
            3'd2:    return 2'b01;
            3'd3:    return 2'b11;
            3'd4:    return model_cond(cbt, a, b) ? 2'b11 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One rising edge; the model tracks the registered state from the inputs held across it.
    task automatic tick();
        logic [1:0] e;
        e = model_pc(branch_type, cond_branch_type, read_data_1, read_data_2);
        @(posedge clock);
        if (!reset_n) begin
            m_q   = 2'b00;
            m_cnt = 32'd0;
        end else begin
            m_q = e;
            if (e != 2'b00 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    // Drive one set of inputs, check the combinational result, clock, check registers.
    task automatic apply(input string tag, input logic [2:0] bt, input logic [2:0] cbt,
                         input logic [31:0] a, input logic [31:0] b, input logic [1:0] want);
        branch_type      = bt;
        cond_branch_type = cbt;
        read_data_1      = a;
        read_data_2      = b;
        #1;
        check({tag, ".pc_src"}, 32'(pc_src), 32'(want));
        check({tag, ".taken"}, 32'(taken), 32'(want != 2'b00));
        tick();
        check({tag, ".pc_src_q"}, 32'(pc_src_q), 32'(m_q));
        check({tag, ".count"}, redirect_count, m_cnt);
    endtask

    initial begin
        logic [2:0]  conds [6];
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  bt;
        logic [2:0]  cbt;
        bit          found;

        conds = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        m_q   = 2'b00;
        m_cnt = 32'd0;

        // Reset state
        reset_n          = 1'b0;
        branch_type      = 3'd0;
        cond_branch_type = 3'd0;
        read_data_1      = 32'd0;
        read_data_2      = 32'd0;
        tick();
        check("reset.pc_src_q", 32'(pc_src_q), 32'd0);
        check("reset.count", redirect_count, 32'd0);
        reset_n = 1'b1;

        // Unconditional kinds
        apply("nobranch", 3'd0, 3'($urandom), $urandom, $urandom, 2'b00);
        apply("mret",     3'd1, 3'($urandom), $urandom, $urandom, 2'b10);
        apply("sret",     3'd2, 3'($urandom), $urandom, $urandom, 2'b01);
        apply("jump",     3'd3, 3'($urandom), $urandom, $urandom, 2'b11);

        // Each condition with a random taken pair then a random not-taken pair
        foreach (conds[i]) begin
            for (int want = 1; want >= 0; want--) begin
                found = 1'b0;
                a = 32'd0;
                b = 32'd0;
                for (int t = 0; t < 500 && !found; t++) begin
                    a = $urandom;
                    b = ($urandom_range(0, 1) == 0) ? a : 32'($urandom);
                    if (model_cond(conds[i], a, b) == bit'(want)) found = 1'b1;
                end
                check("pairgen", 32'(found), 32'd1);
                apply($sformatf("cond%0d_want%0d", conds[i], want), 3'd4, conds[i], a, b,
                      want != 0 ? 2'b11 : 2'b00);
            end
        end

        // Signed versus unsigned boundaries
        apply("blt_neg1_1",   3'd4, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11);
        apply("bltu_neg1_1",  3'd4, 3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        apply("blt_min_max",  3'd4, 3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11);
        apply("bltu_min_max", 3'd4, 3'd6, 32'h8000_0000, 32'h7FFF_FFFF, 2'b00);
        apply("beq_eq",  3'd4, 3'd0, 32'h1234_5678, 32'h1234_5678, 2'b11);
        apply("bge_eq",  3'd4, 3'd5, 32'h1234_5678, 32'h1234_5678, 2'b11);
        apply("bgeu_eq", 3'd4, 3'd7, 32'h1234_5678, 32'h1234_5678, 2'b11);
        apply("blt_eq",  3'd4, 3'd4, 32'h1234_5678, 32'h1234_5678, 2'b00);
        apply("bltu_eq", 3'd4, 3'd6, 32'h1234_5678, 32'h1234_5678, 2'b00);

        // Undefined encodings
        apply("bt5", 3'd5, 3'd0, 32'd7, 32'd7, 2'b00);
        apply("bt6", 3'd6, 3'd0, 32'd7, 32'd7, 2'b00);
        apply("bt7", 3'd7, 3'd5, 32'd7, 32'd7, 2'b00);
        apply("cbt2", 3'd4, 3'd2, 32'd7, 32'd7, 2'b00);
        apply("cbt3", 3'd4, 3'd3, 32'd1, 32'd9, 2'b00);

        // Fully random mix against the model
        for (int i = 0; i < 40; i++) begin
            bt  = 3'($urandom_range(0, 7));
            cbt = 3'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            apply($sformatf("rand%0d", i), bt, cbt, a, b, model_pc(bt, cbt, a, b));
        end

        // Reset mid-operation leaves the combinational path alone and beats the increment
        reset_n     = 1'b0;
        branch_type = 3'd3;
        #1;
        check("rst.pc_src", 32'(pc_src), 32'd3);
        check("rst.taken", 32'(taken), 32'd1);
        tick();
        check("rst.pc_src_q", 32'(pc_src_q), 32'd0);
        check("rst.count", redirect_count, 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_release.count", redirect_count, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("three_jumps.count", redirect_count, 32'd3);
        check("three_jumps.pc_src_q", 32'(pc_src_q), 32'd3);

        // Saturation: preset the counter near its maximum, keep redirecting
        force dut.redirect_count = 32'hFFFF_FFFD;
        tick();
        release dut.redirect_count;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 1) check($sformatf("sat%0d.count", i), redirect_count, 32'hFFFF_FFFF);
        end
        m_cnt = 32'hFFFF_FFFF;
        apply("sat_idle", 3'd0, 3'd0, 32'd0, 32'd0, 2'b00);
        apply("sat_jump", 3'd3, 3'd0, 32'd0, 32'd0, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_decoder_unit.md
BRANCH_DECODER_UNIT -- requirements
Module: branch_decoder_unit

Interface
REQ-001 The block SHALL have one parameter: Width, default 32, meaning the operand width in bits.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all registered state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port branch_type, input, branch_t (3 bits): NoBranch=0, Mret=1, Sret=2, Jump=3, CondBranch=4.
REQ-005 The block SHALL have port cond_branch_type, input, cond_branch_t (3 bits), RISC-V funct3 encoding: Beq=0, Bne=1, Blt=4, Bge=5, Bltu=6, Bgeu=7.
REQ-006 The block SHALL have port read_data_1, input, Width bits: rs1 operand.
REQ-007 The block SHALL have port read_data_2, input, Width bits: rs2 operand.
REQ-008 The block SHALL have port pc_src, output, 2 bits: next-PC select, with PcPlus4Src=00, SepcSrc=01, MepcSrc=10, PcOrReadDataPlusImmSrc=11.
REQ-009 The block SHALL have port taken, output, 1 bit: high when pc_src != 00.
REQ-010 The block SHALL have port pc_src_q, output, 2 bits: pc_src registered one cycle.
REQ-011 The block SHALL have port redirect_count, output, 32 bits: count of cycles with taken=1.
REQ-012 The enum types SHALL be defined in package branch_decoder_unit_pkg.

Function
REQ-013 pc_src and taken SHALL be purely combinational from branch_type, cond_branch_type and the operands, with zero-cycle latency and no dependence on clock or reset_n.
REQ-014 When branch_type is NoBranch, pc_src SHALL be 00.
REQ-015 When branch_type is Sret, pc_src SHALL be 01.
REQ-016 When branch_type is Mret, pc_src SHALL be 10.
REQ-017 When branch_type is Jump, pc_src SHALL be 11.
REQ-018 When branch_type is CondBranch, pc_src SHALL be 11 if the condition holds and 00 otherwise.
REQ-019 Beq SHALL hold when rd1 == rd2; Bne SHALL hold when rd1 != rd2.
REQ-020 Blt SHALL hold when signed rd1 < signed rd2; Bge SHALL hold when signed rd1 >= signed rd2.
REQ-021 Bltu SHALL hold when unsigned rd1 < unsigned rd2; Bgeu SHALL hold when unsigned rd1 >= unsigned rd2.
REQ-022 Signed comparison SHALL interpret the operand MSB as the sign bit at the full Width; boundary cases SHALL give: 0x80000000 <s 0x7FFFFFFF true, <u false; equal operands SHALL make Bge and Bgeu true and Blt and Bltu false.
REQ-023 An undefined branch_type encoding (5-7) SHALL give pc_src=00.
REQ-024 An undefined cond_branch_type encoding (2, 3) under CondBranch SHALL give pc_src=00.
REQ-025 cond_branch_type and the operands SHALL be ignored unless branch_type is CondBranch.
REQ-026 Each rising clock edge with reset_n=1 SHALL load pc_src_q with pc_src.
REQ-027 Each rising clock edge with reset_n=1 and taken=1 SHALL increment redirect_count by 1, saturating at 0xFFFFFFFF with no wrap.

Reset
REQ-028 A rising clock edge with reset_n=0 SHALL set pc_src_q=00 and redirect_count=0; reset SHALL take priority over the counter increment in the same cycle.
REQ-029 Reset asserted mid-operation SHALL NOT affect the combinational pc_src and taken.
REQ-030 Deassertion of reset_n SHALL take effect at the next rising clock edge only, with no asynchronous path.

Verification
REQ-031 NoBranch, Mret, Sret, Jump in turn -> pc_src = 00, 10, 01, 11 respectively, within 1 time unit.
REQ-032 CondBranch with each of Beq/Bne/Blt/Bge/Bltu/Bgeu, using random taken operand pairs then not-taken pairs -> pc_src=11 then 00.
REQ-033 Blt with rd1=0xFFFFFFFF, rd2=0x00000001 -> 11; Bltu with the same operands -> 00.
REQ-034 Beq with rd1=rd2=0x12345678 -> 11, and Bge/Bgeu with the same operands -> 11.
REQ-035 reset_n=0 for one edge, then three cycles of Jump with reset_n=1 -> redirect_count=3 and pc_src_q=11.
REQ-036 Counter preset near saturation, then held taken for several cycles -> redirect_count stays at 0xFFFFFFFF.
